hit_scorer: RTL
===============

Name: hit_scorer

Overview:
- Clocked, parametrised scoring engine for the reaction game.
- Compares keypad codes against the current random target and keeps a multi-digit BCD score.
- Drives one 7-segment pattern per score digit.
- Sits between the keypad encoder / random target generator and the display mux. Replaces the single-digit combinational score decoder.

Parameters:
- NUM_TARGETS, 4, number of target positions; keypad codes 1..NUM_TARGETS map to targets 0..NUM_TARGETS-1.
- KEY_W, 4, width of keypad code; code 0 means no key pressed.
- DIGITS, 2, number of BCD score digits (1..4).
- WRAP, 1, 1 = score wraps from all-9s to 0; 0 = score saturates at all-9s.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_code  in  KEY_W  keypad code; 0 = idle.
- target_sel  in  max(1,$clog2(NUM_TARGETS))  current target index.
- target_valid  in  1  target_sel is meaningful.
- score_clr  in  1  synchronous score clear, one-cycle strobe.
- score_bcd  out  4*DIGITS  score; digit 0 in the LSBs.
- seg  out  8*DIGITS  segment patterns; digit k at [8k+7:8k], bit 7 = a ... bit 1 = g, bit 0 = dp, active high.
- hit  out  1  one-cycle pulse on a scored hit.
- miss  out  1  one-cycle pulse on a non-scoring press.
- wrapped  out  1  one-cycle pulse when the score wraps (WRAP=1) or a hit is discarded at max (WRAP=0).

Behaviour:
- Reset, applied while rst high at a clk edge:
  - key_q = 0, target_q = 0, state = ARMED, score_bcd = 0.
  - hit, miss and wrapped = 0.
  - seg = digit-0 pattern on every digit.
  - Reset mid-round discards any press in that cycle.
- Press detection:
  - press = (key_code != 0) && (key_code != key_q).
  - key_q registers key_code every cycle.
  - A held key produces one press. Changing directly from one nonzero code to another is a new press.
- Round FSM, states ARMED and SCORED:
  - Re-arm: target_valid high and (target_sel != target_q, or target_valid was low last cycle). This forces ARMED in the same cycle, evaluated before hit detection.
  - target_q registers target_sel every cycle.
  - Hit condition: press && state (after re-arm) == ARMED && target_valid && key_code == target_sel+1.
  - Transitions: ARMED -> SCORED on hit. SCORED -> ARMED only on re-arm.
  - Any press that is not a hit pulses miss. This includes: wrong key, key code > NUM_TARGETS, already SCORED, target_valid low.
- Latency:
  - hit and miss are registered and go high the cycle after the clk edge that samples the press.
  - score_bcd updates on that same edge.
  - seg is a combinational decode of score_bcd, so seg changes with score_bcd.
- Score arithmetic:
  - BCD ripple increment: digit 9 -> 0 with carry into the next digit.
  - Only values 0-9 ever appear per digit.
  - All-9s plus hit: WRAP=1 gives 0 and pulses wrapped. WRAP=0 holds all-9s, still pulses hit and pulses wrapped.
- Priority in one cycle: rst > score_clr > hit/miss update.
  - score_clr zeroes the score and sets state ARMED.
  - A simultaneous press is ignored: no hit, no miss.
  - key_q and target_q still update.
- Segment codes (a..g,dp): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6. Any other digit value gives 00.

Optional Feature:
- Macro MISS_PENALTY_EN.
- Defined: each miss decrements score_bcd by one (BCD borrow: 0 -> 9 with borrow). Score floors at 0, and decrementing from 0 leaves 0. wrapped is never pulsed by a decrement.
- Undefined: miss only pulses; score is unaffected.

Decomposition:
- Package hit_scorer_pkg: SEG_0..SEG_9 and SEG_BLANK constants; state enum type (ARMED, SCORED); BCD digit typedef (4 bits).
- Sub-module seg7_decode: one BCD digit in, 8-bit pattern out, combinational. Instantiated DIGITS times through a generate loop.

Test Plan:
- Reset, then idle with key_code=0 for 10 cycles -> score_bcd=0, seg=FCFC, no pulses.
- target_sel=2, target_valid=1, key_code 0->3 held 5 cycles -> exactly one hit one cycle after the press, score=01, seg low byte=60. A second press of 3 after releasing to 0 -> miss, score stays 01.
- target_sel 2->0, then key_code=1 -> re-armed, hit, score=02. Then key_code=2 with target 0 -> miss.
- Preload to 99 via 99 hits: WRAP=1, next hit -> score=00 and wrapped pulse. WRAP=0, next hit -> score=99, hit and wrapped pulse.
- score_clr asserted in the same cycle as a valid hitting press -> score=00, no hit, no miss. Next re-armed press scores 01.
- MISS_PENALTY_EN defined: score=10, wrong key -> 09. At score=00, wrong key -> 00 with a miss pulse.

Source files
------------

// File: rtl/hit_scorer_pkg.sv
// Shared types and constants for the reaction-game scorer: segment patterns,
// round state encoding and the BCD digit type.
package hit_scorer_pkg;

    // Segment patterns, bit 7 = a ... bit 1 = g, bit 0 = dp, active high
    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic {
        ARMED  = 1'b0,
        SCORED = 1'b1
    } state_e;

    typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to an 8-bit a..g,dp segment pattern; non-decimal codes blank.
module seg7_decode
    import hit_scorer_pkg::*;
(
    input  bcd_t       digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hit_scorer.sv
// Reaction-game scoring engine: keypad press vs. target, BCD score, 7-seg out.
// Optional MISS_PENALTY_EN makes every miss decrement the score (floored at 0).
module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int KEY_W       = 4,
    parameter int DIGITS      = 2,
    parameter int WRAP        = 1,
    localparam int TSEL_W     = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_W-1:0]      key_code,
    input  logic [TSEL_W-1:0]     target_sel,
    input  logic                  target_valid,
    input  logic                  score_clr,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  hit,
    output logic                  miss,
    output logic                  wrapped
);

    // Wide enough to hold target_sel+1 and any key code without truncation
    localparam int CMP_W = ((KEY_W > TSEL_W) ? KEY_W : TSEL_W) + 1;

    logic [KEY_W-1:0]      key_q, key_d;
    logic [TSEL_W-1:0]     target_q, target_d;
    logic                  tvalid_q, tvalid_d;
    state_e                state_q, state_d;
    bcd_t [DIGITS-1:0]     score_q, score_d;
    logic                  hit_q, hit_d;
    logic                  miss_q, miss_d;
    logic                  wrapped_q, wrapped_d;

    logic                  press;
    logic                  rearm;
    state_e                state_eff;
    logic                  key_match;
    logic                  hit_now;
    logic [CMP_W-1:0]      key_ext;
    logic [CMP_W-1:0]      tgt_ext;

    bcd_t [DIGITS-1:0]     score_inc;
    logic                  all_nines;

    // Press detection and re-arm are both edge-style comparisons against last cycle
    always_comb begin
        press     = (key_code != '0) && (key_code != key_q);
        rearm     = target_valid && ((target_sel != target_q) || !tvalid_q);
        state_eff = rearm ? ARMED : state_q;
        key_ext   = CMP_W'(key_code);
        tgt_ext   = CMP_W'(target_sel) + CMP_W'(1);
        key_match = (key_ext == tgt_ext) && (key_ext <= CMP_W'(NUM_TARGETS));
        hit_now   = press && (state_eff == ARMED) && target_valid && key_match;
    end

    always_comb begin
        logic carry;
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score_q[i] == 4'd9) begin
                    score_inc[i] = 4'd0;
                end else begin
                    score_inc[i] = score_q[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

`ifdef MISS_PENALTY_EN
    bcd_t [DIGITS-1:0]     score_dec;
    logic                  score_zero;

    always_comb begin
        logic borrow;
        score_dec  = score_q;
        borrow     = 1'b1;
        score_zero = (score_q == '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (score_q[i] == 4'd0) begin
                    score_dec[i] = 4'd9;
                end else begin
                    score_dec[i] = score_q[i] - 4'd1;
                    borrow       = 1'b0;
                end
            end
        end
    end
`endif

    always_comb begin
        key_d     = key_code;
        target_d  = target_sel;
        tvalid_d  = target_valid;
        state_d   = state_eff;
        score_d   = score_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        wrapped_d = 1'b0;

        if (score_clr) begin
            score_d = '0;
            state_d = ARMED;
        end else if (hit_now) begin
            state_d = SCORED;
            hit_d   = 1'b1;
            if (all_nines) begin
                wrapped_d = 1'b1;
                score_d   = (WRAP != 0) ? score_inc : score_q;
            end else begin
                score_d = score_inc;
            end
        end else if (press) begin
            miss_d = 1'b1;
`ifdef MISS_PENALTY_EN
            if (!score_zero)
                score_d = score_dec;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            target_q  <= '0;
            tvalid_q  <= 1'b0;
            state_q   <= ARMED;
            score_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            target_q  <= target_d;
            tvalid_q  <= tvalid_d;
            state_q   <= state_d;
            score_q   <= score_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign score_bcd = score_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign wrapped   = wrapped_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_seg
        seg7_decode u_dec (
            .digit (score_q[k]),
            .seg   (seg[8*k +: 8])
        );
    end

endmodule
